// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - note codes, effect indices and the constant sound-effect table
package sfx_pkg;

   localparam int NOTE_BITS = 6;
   localparam int DUR_BITS  = 6;

   localparam logic [NOTE_BITS-1:0] NOTE_SILENT = 6'd0;
   localparam logic [NOTE_BITS-1:0] NOTE_C4     = 6'd1;
   localparam logic [NOTE_BITS-1:0] NOTE_D4     = 6'd2;
   localparam logic [NOTE_BITS-1:0] NOTE_E4     = 6'd3;
   localparam logic [NOTE_BITS-1:0] NOTE_F4     = 6'd4;
   localparam logic [NOTE_BITS-1:0] NOTE_G4     = 6'd5;
   localparam logic [NOTE_BITS-1:0] NOTE_A4     = 6'd6;
   localparam logic [NOTE_BITS-1:0] NOTE_B4     = 6'd7;
   localparam logic [NOTE_BITS-1:0] NOTE_C5     = 6'd8;
   localparam logic [NOTE_BITS-1:0] NOTE_D5     = 6'd9;
   localparam logic [NOTE_BITS-1:0] NOTE_E5     = 6'd10;
   localparam logic [NOTE_BITS-1:0] NOTE_F5     = 6'd11;
   localparam logic [NOTE_BITS-1:0] NOTE_G5     = 6'd12;

   localparam int SFX_HIT   = 0;
   localparam int SFX_WIN   = 1;
   localparam int SFX_PAUSE = 2;
   localparam int SFX_MISS  = 3;

   typedef enum logic {ST_IDLE, ST_PLAY} sfx_state_t;

   typedef struct packed {
      logic [NOTE_BITS-1:0] note;
      logic [DUR_BITS-1:0]  dur;
   } sfx_step_t;

   // dur == 0 terminates an effect; SFX_MISS is a reserved empty slot.
   function automatic sfx_step_t sfx_entry(input int unsigned id, input int unsigned step);
      sfx_step_t e;
      e.note = NOTE_SILENT;
      e.dur  = '0;
      case (id)
         SFX_HIT: begin
            case (step)
               0: e = '{note: NOTE_C4, dur: 6'd2};
               1: e = '{note: NOTE_D4, dur: 6'd1};
               2: e = '{note: NOTE_E4, dur: 6'd3};
               default: ;
            endcase
         end
         SFX_WIN: begin
            case (step)
               0: e = '{note: NOTE_E5, dur: 6'd1};
               1: e = '{note: NOTE_F5, dur: 6'd1};
               default: ;
            endcase
         end
         SFX_PAUSE: begin
            // open-ended click train, cut off by the step limit
            e.note = (step % 2 == 0) ? NOTE_C5 : NOTE_G5;
            e.dur  = 6'd1;
         end
         default: ;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sfx_rom.sv
// rtl/sfx_rom.sv - combinational effect-table lookup; out-of-range id or step reads as end of effect
module sfx_rom
   import sfx_pkg::*;
#(
   parameter int NOTE_W    = 6,
   parameter int DUR_W     = 6,
   parameter int N_SFX     = 4,
   parameter int MAX_STEPS = 16
) (
   input  logic [$clog2(N_SFX)-1:0]     id,
   input  logic [$clog2(MAX_STEPS)-1:0] step,
   output logic [NOTE_W-1:0]            note,
   output logic [DUR_W-1:0]             dur
);

   sfx_step_t e;

   always_comb begin
      e    = sfx_entry(32'(id), 32'(step));
      note = NOTE_W'(e.note);
      dur  = DUR_W'(e.dur);
      if (int'(id) >= N_SFX || int'(step) >= MAX_STEPS) begin
         note = '0;
         dur  = '0;
      end
   end

endmodule

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - priority/preempting sound-effect sequencer driving the buzzer note bus
// Optional one-deep pending slot for lower-priority requests: define SFX_QUEUE_EN.
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int NOTE_W    = 6,
   parameter int DUR_W     = 6,
   parameter int N_SFX     = 4,
   parameter int MAX_STEPS = 16,
   parameter int TICK_DIV  = 500000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enabled,
   input  logic [N_SFX-1:0]         trig,
   output logic [NOTE_W-1:0]        note,
   output logic                     busy,
   output logic [$clog2(N_SFX)-1:0] active_sfx
);

   localparam int IDW = $clog2(N_SFX);
   localparam int SW  = $clog2(MAX_STEPS);
   localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   sfx_state_t        state;
   logic [N_SFX-1:0]  trig_q;
   logic [N_SFX-1:0]  rise;
   logic [SW-1:0]     step;
   logic [SW-1:0]     next_step;
   logic [DUR_W-1:0]  remaining;
   logic [PW-1:0]     prescaler;
   logic [IDW-1:0]    sel;
   logic              sel_hit;
   logic [NOTE_W-1:0] sel_note;
   logic [DUR_W-1:0]  sel_dur;
   logic [NOTE_W-1:0] next_note;
   logic [DUR_W-1:0]  next_dur;
   logic              accept;
   logic              tick;
   logic              last_step;
   logic              effect_end;
   logic              pend_start;
   logic              do_start;
   logic [IDW-1:0]    start_id;
   logic [NOTE_W-1:0] start_note;
   logic [DUR_W-1:0]  start_dur;

   assign rise      = trig & ~trig_q;
   assign next_step = step + SW'(1);

   always_comb begin
      sel     = '0;
      sel_hit = 1'b0;
      for (int i = N_SFX - 1; i >= 0; i--) begin
         if (rise[i]) begin
            sel     = IDW'(i);
            sel_hit = 1'b1;
         end
      end
   end

   sfx_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .N_SFX(N_SFX), .MAX_STEPS(MAX_STEPS)) u_rom_sel (
      .id   (sel),
      .step ({SW{1'b0}}),
      .note (sel_note),
      .dur  (sel_dur)
   );

   sfx_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .N_SFX(N_SFX), .MAX_STEPS(MAX_STEPS)) u_rom_next (
      .id   (active_sfx),
      .step (next_step),
      .note (next_note),
      .dur  (next_dur)
   );

   // Equal index is accepted too, so re-triggering the playing effect restarts it.
   assign accept     = enabled && sel_hit && (sel_dur != '0) &&
                       (state == ST_IDLE || sel <= active_sfx);
   assign tick       = (state == ST_PLAY) && (prescaler == PW'(TICK_DIV - 1));
   assign last_step  = (step == SW'(MAX_STEPS - 1)) || (next_dur == '0);
   assign effect_end = (state == ST_PLAY) && tick && (remaining == DUR_W'(1)) && last_step;

`ifdef SFX_QUEUE_EN
   logic              pend_valid;
   logic [IDW-1:0]    pend_id;
   logic [NOTE_W-1:0] pend_note;
   logic [DUR_W-1:0]  pend_dur;
   logic [IDW-1:0]    q_base;
   logic [IDW-1:0]    q_id;
   logic              q_hit;

   sfx_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .N_SFX(N_SFX), .MAX_STEPS(MAX_STEPS)) u_rom_pend (
      .id   (pend_id),
      .step ({SW{1'b0}}),
      .note (pend_note),
      .dur  (pend_dur)
   );

   // Best lower-priority request this cycle, relative to whatever plays next cycle.
   always_comb begin
      q_base = accept ? sel : active_sfx;
      q_hit  = 1'b0;
      q_id   = '0;
      for (int i = N_SFX - 1; i >= 0; i--) begin
         if (rise[i] && IDW'(i) > q_base) begin
            q_hit = 1'b1;
            q_id  = IDW'(i);
         end
      end
   end

   assign pend_start = enabled && !accept && effect_end && pend_valid && (pend_dur != '0);
   assign start_id   = accept ? sel : pend_id;
   assign start_note = accept ? sel_note : pend_note;
   assign start_dur  = accept ? sel_dur : pend_dur;
`else
   assign pend_start = 1'b0;
   assign start_id   = sel;
   assign start_note = sel_note;
   assign start_dur  = sel_dur;
`endif

   assign do_start = accept || pend_start;

   always_ff @(posedge clk) begin
      trig_q <= trig;
      if (reset || !enabled) begin
         state      <= ST_IDLE;
         note       <= '0;
         busy       <= 1'b0;
         active_sfx <= '0;
         step       <= '0;
         remaining  <= '0;
         prescaler  <= '0;
`ifdef SFX_QUEUE_EN
         pend_valid <= 1'b0;
         pend_id    <= '0;
`endif
      end else begin
         if (do_start) begin
            state      <= ST_PLAY;
            busy       <= 1'b1;
            active_sfx <= start_id;
            step       <= '0;
            note       <= start_note;
            remaining  <= start_dur;
            prescaler  <= '0;
         end else if (state == ST_PLAY) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
               if (remaining > DUR_W'(1)) begin
                  remaining <= remaining - DUR_W'(1);
               end else if (last_step) begin
                  state      <= ST_IDLE;
                  note       <= '0;
                  busy       <= 1'b0;
                  active_sfx <= '0;
                  step       <= '0;
                  remaining  <= '0;
                  prescaler  <= '0;
               end else begin
                  step      <= next_step;
                  note      <= next_note;
                  remaining <= next_dur;
               end
            end
         end
`ifdef SFX_QUEUE_EN
         if (accept) begin
            pend_valid <= q_hit;
            pend_id    <= q_id;
         end else if (effect_end) begin
            pend_valid <= 1'b0;
         end else if (state == ST_PLAY && q_hit && (!pend_valid || q_id < pend_id)) begin
            pend_valid <= 1'b1;
            pend_id    <= q_id;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb/tb_sfx_sequencer.sv - directed and random checks of sfx_sequencer against a cycle-count model
module tb_sfx_sequencer;

   localparam int N_SFX     = 4;
   localparam int MAX_STEPS = 16;
   localparam int TICK_DIV  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enabled = 1'b0;
   logic [3:0] trig = 4'd0;
   logic [5:0] note;
   logic       busy;
   logic [1:0] active_sfx;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sfx_sequencer #(
      .NOTE_W(6), .DUR_W(6), .N_SFX(N_SFX), .MAX_STEPS(MAX_STEPS), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enabled    (enabled),
      .trig       (trig),
      .note       (note),
      .busy       (busy),
      .active_sfx (active_sfx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference table written straight from the effect list.
   function automatic int t_note(input int id, input int s);
      case (id)
         0: return (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 3 : 0;
         1: return (s == 0) ? 10 : (s == 1) ? 11 : 0;
         2: return (s % 2 == 0) ? 8 : 12;
         default: return 0;
      endcase
   endfunction

   function automatic int t_dur(input int id, input int s);
      case (id)
         0: return (s == 0) ? 2 : (s == 1) ? 1 : (s == 2) ? 3 : 0;
         1: return (s < 2) ? 1 : 0;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   // Model: each step simply lasts dur*TICK_DIV cycles.
   bit         m_play = 1'b0;
   int         m_id = 0, m_step = 0, m_left = 0;
   bit         m_pv = 1'b0;
   int         m_pid = 0;
   logic [3:0] m_prev = 4'd0;

   task automatic m_start(input int id);
      m_play = 1'b1;
      m_id   = id;
      m_step = 0;
      m_left = t_dur(id, 0) * TICK_DIV;
   endtask

   task automatic model_edge(input logic [3:0] t, input logic en, input logic rst);
      logic [3:0] r;
      int sel, qid, base;
      bit acc, ended;
      r = t & ~m_prev;
      m_prev = t;
      if (rst || !en) begin
         m_play = 1'b0;
         m_pv   = 1'b0;
         return;
      end
      sel = -1;
      for (int i = N_SFX - 1; i >= 0; i--) if (r[i]) sel = i;
      acc = (sel >= 0) && (t_dur(sel, 0) > 0) && (!m_play || sel <= m_id);
      base = acc ? sel : m_id;
      qid = -1;
      for (int i = N_SFX - 1; i >= 0; i--) if (r[i] && i > base) qid = i;
      ended = 1'b0;
      if (acc) begin
         m_start(sel);
`ifdef SFX_QUEUE_EN
         m_pv  = (qid >= 0);
         m_pid = qid;
`endif
      end else if (m_play) begin
         m_left--;
         if (m_left == 0) begin
            if (m_step + 1 == MAX_STEPS || t_dur(m_id, m_step + 1) == 0) ended = 1'b1;
            else begin
               m_step++;
               m_left = t_dur(m_id, m_step) * TICK_DIV;
            end
         end
`ifdef SFX_QUEUE_EN
         if (ended) begin
            if (m_pv && t_dur(m_pid, 0) > 0) begin
               m_pv = 1'b0;
               m_start(m_pid);
            end else begin
               m_pv   = 1'b0;
               m_play = 1'b0;
            end
         end else if (qid >= 0 && (!m_pv || qid < m_pid)) begin
            m_pv  = 1'b1;
            m_pid = qid;
         end
`else
         if (ended) m_play = 1'b0;
`endif
      end
   endtask

   task automatic cyc(input logic [3:0] t, input logic en, input logic rst);
      trig    = t;
      enabled = en;
      reset   = rst;
      @(posedge clk);
      model_edge(t, en, rst);
      #1;
      check("note", 32'(note), m_play ? t_note(m_id, m_step) : 0);
      check("busy", 32'(busy), 32'(m_play));
      check("active_sfx", 32'(active_sfx), m_play ? m_id : 0);
   endtask

   task automatic run(input logic [3:0] t);
      cyc(t, 1'b1, 1'b0);
   endtask

   // Holds t from the triggering edge and counts busy cycles (bounded).
   task automatic count_play(input logic [3:0] t, output int n);
      n = 0;
      run(t);
      while (busy && n < 200) begin
         n++;
         run(t);
      end
   endtask

   initial begin
      int n;
      logic [3:0] t;
      logic en, rst;

      repeat (3) cyc(4'd0, 1'b1, 1'b1);
      repeat (5) run(4'd0);

      count_play(4'b0001, n);
      check("sfx0_len", n, (2 + 1 + 3) * TICK_DIV);
      run(4'd0);

      run(4'b0010);
      repeat (2) run(4'b0010);
      run(4'b0011);
      check("preempt_id", 32'(active_sfx), 0);
      check("preempt_note", 32'(note), 1);
      repeat (30) run(4'd0);

      run(4'b0001);
      repeat (3) run(4'd0);
      run(4'b0010);
      check("low_ignored_id", 32'(active_sfx), 0);
      repeat (30) run(4'd0);

      repeat (2) cyc(4'b0001, 1'b1, 1'b1);
      repeat (4) run(4'b0001);
      check("held_reset_busy", 32'(busy), 0);
      run(4'd0);

      run(4'b0001);
      repeat (5) run(4'd0);
      cyc(4'd0, 1'b0, 1'b0);
      check("disable_busy", 32'(busy), 0);
      check("disable_note", 32'(note), 0);
      cyc(4'b0001, 1'b0, 1'b0);
      run(4'b0001);
      check("held_enable_busy", 32'(busy), 0);
      run(4'd0);

      run(4'b0001);
      repeat (23) run(4'd0);
      check("final_step_note", 32'(note), 3);
      run(4'b0001);
      check("restart_note", 32'(note), 1);
      check("restart_busy", 32'(busy), 1);
      repeat (30) run(4'd0);

      run(4'b0011);
      check("simul_id", 32'(active_sfx), 0);
      repeat (30) run(4'd0);

      count_play(4'b0100, n);
      check("sfx2_len", n, MAX_STEPS * TICK_DIV);
      run(4'd0);

      run(4'b1000);
      check("empty_sfx_busy", 32'(busy), 0);
      run(4'd0);

      t  = 4'd0;
      en = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N_SFX; i++) if ($urandom_range(0, 40) == 0) t[i] = ~t[i];
         if ($urandom_range(0, 150) == 0) en = ~en;
         rst = ($urandom_range(0, 500) == 0);
         cyc(t, en, rst);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
